// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the widths of the status and
// sequence-tag fields used by the ALU, its dispatcher and their benches.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SUB    = 2'b00,
    OP_CMP    = 2'b01,
    OP_SHIFT  = 2'b10,
    OP_BITCHG = 2'b11
  } alu_op_e;

  localparam int STATUS_W = 4;
  localparam int TAG_W    = 2;

endpackage

// File: rtl/alu_dispatch_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is accepted
// when a pop happens in the same cycle, so occupancy stays constant.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          full, empty, push_ok, pop_ok;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push_i & (~full | pop_i);
  assign pop_ok  = pop_i & ~empty;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Storage array: data only, no reset needed since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= bump(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= bump(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Command dispatcher in front of the ALU: buffers (op, a, b) commands, issues
// at most one per cycle under a credit scheme that guarantees a free result
// slot, tracks in-flight commands over the fixed ALU latency and queues the
// tagged ALU results for the consumer.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 2,
  parameter int ALU_LAT   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_vld,
  output logic                o_cmd_rdy,
  input  logic [1:0]          i_cmd_op,
  input  logic [BITS-1:0]     i_cmd_a,
  input  logic [BITS-1:0]     i_cmd_b,
  output logic [1:0]          o_alu_op,
  output logic [BITS-1:0]     o_alu_a,
  output logic [BITS-1:0]     o_alu_b,
  output logic                o_alu_vld,
  input  logic [BITS-1:0]     i_alu_out,
  input  logic [STATUS_W-1:0] i_alu_status,
  output logic                o_res_vld,
  input  logic                i_res_rdy,
  output logic [BITS-1:0]     o_res_data,
  output logic [STATUS_W-1:0] o_res_status,
  output logic [TAG_W-1:0]    o_res_tag,
  output logic                o_busy
);

  localparam int CMD_W = 2 + 2 * BITS;
  localparam int RES_W = BITS + STATUS_W + TAG_W;
  localparam int CCW   = $clog2(CMD_DEPTH + 1);
  localparam int RCW   = $clog2(RES_DEPTH + 1);

  logic [CMD_W-1:0] cmd_rdata;
  logic [CCW-1:0]   cmd_cnt;
  logic             cmd_full, cmd_push;
  logic [RES_W-1:0] res_wdata, res_rdata;
  logic [RCW-1:0]   res_cnt;
  logic             res_push, res_pop;

  // Issue stage registers; bit 0 of the flight chain is the issue cycle itself,
  // the top entry marks the cycle in which the ALU result is valid.
  alu_op_e                        alu_op_q;
  logic [BITS-1:0]                alu_a_q, alu_b_q;
  logic [ALU_LAT:0]               flight_vld_q;
  logic [(ALU_LAT+1)*TAG_W-1:0]   flight_tag_q;
  logic [TAG_W-1:0]               tag_cnt_q, tag_cnt_d;

  int   occ;
  logic issue;

  sync_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .push_i  (cmd_push),
    .wdata_i ({i_cmd_op, i_cmd_a, i_cmd_b}),
    .pop_i   (issue),
    .rdata_o (cmd_rdata),
    .count_o (cmd_cnt)
  );

  sync_fifo #(.W(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .push_i  (res_push),
    .wdata_i (res_wdata),
    .pop_i   (res_pop),
    .rdata_o (res_rdata),
    .count_o (res_cnt)
  );

  // Ready is forced low while reset is asserted, independent of the clock.
  assign cmd_full  = (cmd_cnt == CCW'(CMD_DEPTH));
  assign o_cmd_rdy = i_rst & ~cmd_full;
  assign cmd_push  = i_cmd_vld & o_cmd_rdy;

  // Result slots already promised: every in-flight command plus buffered results.
  always_comb begin
    occ = int'(res_cnt);
    for (int i = 0; i <= ALU_LAT; i++) occ += int'(flight_vld_q[i]);
  end

  assign issue     = (cmd_cnt != '0) && (occ < RES_DEPTH);
  assign tag_cnt_d = issue ? tag_cnt_q + TAG_W'(1) : tag_cnt_q;

  // Operand registers hold their last value between issues to keep the ALU inputs stable.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      alu_op_q  <= OP_SUB;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      tag_cnt_q <= '0;
    end else begin
      tag_cnt_q <= tag_cnt_d;
      if (issue) begin
        alu_op_q <= alu_op_e'(cmd_rdata[CMD_W-1 -: 2]);
        alu_a_q  <= cmd_rdata[2*BITS-1 -: BITS];
        alu_b_q  <= cmd_rdata[BITS-1:0];
      end
    end
  end

  // In-flight shift register carrying {valid, tag} from issue to result capture.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      flight_vld_q <= '0;
      flight_tag_q <= '0;
    end else begin
      flight_vld_q <= {flight_vld_q[ALU_LAT-1:0], issue};
      flight_tag_q <= {flight_tag_q[ALU_LAT*TAG_W-1:0], tag_cnt_q};
    end
  end

  assign o_alu_op  = alu_op_q;
  assign o_alu_a   = alu_a_q;
  assign o_alu_b   = alu_b_q;
  assign o_alu_vld = flight_vld_q[0];

  assign res_push  = flight_vld_q[ALU_LAT];
  assign res_wdata = {i_alu_out, i_alu_status, flight_tag_q[(ALU_LAT+1)*TAG_W-1 -: TAG_W]};

  // Head result is masked while empty so stale buffer contents never leak out.
  assign o_res_vld = (res_cnt != '0);
  assign res_pop   = o_res_vld & i_res_rdy;
  assign {o_res_data, o_res_status, o_res_tag} = o_res_vld ? res_rdata : '0;

  assign o_busy = (cmd_cnt != '0) | (|flight_vld_q) | (res_cnt != '0);

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int BITS      = 8;
  localparam int CMD_DEPTH = 4;
  localparam int RES_DEPTH = 2;
  localparam int ALU_LAT   = 1;

  logic       clk, rst_n;
  logic       i_cmd_vld, o_cmd_rdy;
  logic [1:0] i_cmd_op, o_alu_op;
  logic [7:0] i_cmd_a, i_cmd_b, o_alu_a, o_alu_b, i_alu_out, o_res_data;
  logic       o_alu_vld, o_res_vld, i_res_rdy, o_busy;
  logic [3:0] i_alu_status, o_res_status;
  logic [1:0] o_res_tag;

  alu_dispatch #(.BITS(BITS), .CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy), .i_cmd_op(i_cmd_op),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_vld(o_alu_vld),
    .i_alu_out(i_alu_out), .i_alu_status(i_alu_status),
    .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_res_data(o_res_data),
    .o_res_status(o_res_status), .o_res_tag(o_res_tag), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: expected event never occurred", nm);
  endtask

  // ALU behaviour: result and a status of {zero, sign, op}.
  function automatic logic [11:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      2'b00:   r = a - b;
      2'b01:   r = (a < b) ? 8'd1 : 8'd0;
      2'b10:   r = a << b[2:0];
      default: r = a ^ (8'd1 << b[2:0]);
    endcase
    return {r, (r == 8'd0), r[7], op};
  endfunction

  // ALU model with ALU_LAT register stages.
  logic [11:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    for (int k = ALU_LAT - 1; k > 0; k--) alu_pipe[k] <= alu_pipe[k-1];
    alu_pipe[0] <= alu_f(o_alu_op, o_alu_a, o_alu_b);
  end
  assign i_alu_out    = alu_pipe[ALU_LAT-1][11:4];
  assign i_alu_status = alu_pipe[ALU_LAT-1][3:0];

  // Reference model: accepted commands in order, issued commands with tags.
  typedef struct { logic [1:0] op; logic [7:0] a; logic [7:0] b; } cmd_t;
  typedef struct { cmd_t c; logic [1:0] tag; } exp_t;
  cmd_t       acc_q [$];
  exp_t       exp_q [$];
  logic [1:0] popped_tags [$];
  int         acc_n, iss_n, pop_n;
  logic [1:0] tag_m;
  cmd_t       mc;
  exp_t       me;
  logic [11:0] mref;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete(); exp_q.delete();
      acc_n = 0; iss_n = 0; pop_n = 0; tag_m = 2'd0;
    end else begin
      if (o_alu_vld) begin
        if (acc_q.size() == 0) fail_now("issue_without_accepted_cmd");
        else begin
          mc = acc_q.pop_front();
          chk("issue_cmd", {o_alu_op, o_alu_a, o_alu_b}, {mc.op, mc.a, mc.b});
          me.c = mc; me.tag = tag_m;
          exp_q.push_back(me);
        end
        tag_m = tag_m + 2'd1;
        iss_n++;
      end
      chk("cmd_rdy", o_cmd_rdy, (acc_n - iss_n) < CMD_DEPTH);
      chk("res_overflow", (iss_n - pop_n) <= RES_DEPTH, 1);
      chk("busy", o_busy, acc_n != pop_n);
      if (i_cmd_vld && o_cmd_rdy) begin
        mc.op = i_cmd_op; mc.a = i_cmd_a; mc.b = i_cmd_b;
        acc_q.push_back(mc);
        acc_n++;
      end
      if (o_res_vld && i_res_rdy) begin
        if (exp_q.size() == 0) fail_now("result_without_issue");
        else begin
          me = exp_q.pop_front();
          mref = alu_f(me.c.op, me.c.a, me.c.b);
          chk("res_data", o_res_data, mref[11:4]);
          chk("res_status", o_res_status, mref[3:0]);
          chk("res_tag", o_res_tag, me.tag);
        end
        popped_tags.push_back(o_res_tag);
        pop_n++;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    i_cmd_vld = 1'b1; i_cmd_op = op; i_cmd_a = a; i_cmd_b = b;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (o_cmd_rdy) begin
        @(posedge clk); #1;
        i_cmd_vld = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    i_cmd_vld = 1'b0;
    fail_now("send_timeout");
  endtask

  task automatic send_rand();
    send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (o_res_vld) begin ok = 1'b1; return; end
    end
    fail_now("wait_result_timeout");
  endtask

  task automatic drain();
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #1;
      if (!o_busy && acc_n == pop_n) begin
        chk("drain_queue_empty", exp_q.size(), 0);
        return;
      end
    end
    fail_now("drain_timeout");
  endtask

  task automatic assert_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    settle(1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_cmd_rdy"}, o_cmd_rdy, 0);
    chk({nm, "_alu_vld"}, o_alu_vld, 0);
    chk({nm, "_alu_opab"}, {o_alu_op, o_alu_a, o_alu_b}, 0);
    chk({nm, "_res_vld"}, o_res_vld, 0);
    chk({nm, "_res_fields"}, {o_res_data, o_res_status, o_res_tag}, 0);
    chk({nm, "_busy"}, o_busy, 0);
  endtask

  typedef struct { logic [1:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] d; logic [1:0] tag; } vec_t;
  vec_t tbl [8];
  bit   ok;
  int   base;
  bit   t6_done;

  initial begin
    tbl[0] = '{2'b00, 8'h00, 8'h01, 8'hFF, 2'd1};
    tbl[1] = '{2'b01, 8'h05, 8'h09, 8'h01, 2'd2};
    tbl[2] = '{2'b01, 8'h09, 8'h05, 8'h00, 2'd3};
    tbl[3] = '{2'b10, 8'h81, 8'h01, 8'h02, 2'd0};
    tbl[4] = '{2'b11, 8'h00, 8'h03, 8'h08, 2'd1};
    tbl[5] = '{2'b10, 8'h0F, 8'h0C, 8'hF0, 2'd2};
    tbl[6] = '{2'b11, 8'hFF, 8'h07, 8'h7F, 2'd3};
    tbl[7] = '{2'b00, 8'h80, 8'h01, 8'h7F, 2'd0};

    rst_n = 1'b0; i_cmd_vld = 1'b0; i_cmd_op = 2'b00; i_cmd_a = 8'h00; i_cmd_b = 8'h00; i_res_rdy = 1'b0;
    #2;
    check_zero("reset");
    release_reset();
    i_res_rdy = 1'b1;

    // Single SUB: issue one cycle after accept, result ALU_LAT+1 cycles after issue.
    send(OP_SUB, 8'h6F, 8'h18);
    @(negedge clk); chk("t1_no_issue_yet", o_alu_vld, 0);
    @(negedge clk); chk("t1_issue", o_alu_vld, 1);
    repeat (ALU_LAT) begin @(negedge clk); chk("t1_res_not_yet", o_res_vld, 0); end
    @(negedge clk);
    chk("t1_res_vld", o_res_vld, 1);
    chk("t1_res_data", o_res_data, 8'h57);
    chk("t1_res_tag", o_res_tag, 0);
    drain();

    // Table of single transactions with constant expectations.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_res(ok);
      if (ok) begin
        chk($sformatf("tbl%0d_data", i), o_res_data, tbl[i].d);
        chk($sformatf("tbl%0d_tag", i), o_res_tag, tbl[i].tag);
      end
      settle(1);
    end
    drain();

    // Credit limit with a stalled consumer, then a full FIFO, then drain in order.
    assert_reset();
    release_reset();
    popped_tags.delete();
    i_res_rdy = 1'b0;
    base = iss_n;
    for (int i = 0; i < 4; i++) send_rand();
    settle(4);
    chk("t2_issued_eq_credits", iss_n - base, RES_DEPTH);
    chk("t2_rdy_not_full", o_cmd_rdy, 1);
    for (int i = 0; i < 2; i++) send_rand();
    settle(1);
    chk("t2_rdy_when_full", o_cmd_rdy, 0);
    fork
      begin for (int i = 0; i < 2; i++) send_rand(); end
      begin settle(3); i_res_rdy = 1'b1; end
    join
    drain();
    chk("t2_result_count", popped_tags.size(), 8);
    for (int i = 0; i < 8 && i < popped_tags.size(); i++)
      chk($sformatf("t2_tag%0d", i), popped_tags[i], i % 4);

    // Full FIFO while pops free credits and new pushes arrive.
    i_res_rdy = 1'b0;
    base = pop_n;
    for (int i = 0; i < 6; i++) send_rand();
    fork
      begin for (int i = 0; i < 4; i++) send_rand(); end
      begin settle(2); i_res_rdy = 1'b1; end
    join
    drain();
    chk("t4_no_loss", pop_n - base, 10);

    // Random back-to-back stream.
    base = pop_n;
    for (int i = 0; i < 16; i++) send_rand();
    drain();
    chk("t3_stream_count", pop_n - base, 16);

    // Asynchronous reset with commands queued and in flight.
    send_rand(); send_rand(); send_rand();
    #2 rst_n = 1'b0;
    #1;
    check_zero("t5_midreset");
    release_reset();
    settle(5);
    chk("t5_no_stale_vld", o_res_vld, 0);
    chk("t5_idle", o_busy, 0);
    send(OP_SUB, 8'h10, 8'h03);
    wait_res(ok);
    if (ok) begin
      chk("t5_first_tag", o_res_tag, 0);
      chk("t5_first_data", o_res_data, 8'h0D);
    end
    drain();

    // Randomly throttled consumer over 50 commands.
    base = pop_n;
    t6_done = 1'b0;
    fork
      begin for (int i = 0; i < 50; i++) send_rand(); t6_done = 1'b1; end
      begin while (!t6_done) begin @(posedge clk); #1; i_res_rdy = 1'($urandom_range(0, 1)); end end
    join
    i_res_rdy = 1'b1;
    drain();
    chk("t6_count", pop_n - base, 50);
    chk("t6_busy_low", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
